// File: rtl/rr_dmux_4bit.sv
// Round-robin / fixed-destination demultiplexer.
// One input stream is distributed over four output channels. Each channel
// has its own single-word holding register with a valid/ready handshake.
// The target channel is either the round-robin pointer or an explicit
// destination. The input stalls when the target channel is full and not
// draining; it never skips to another channel.

// Single-entry holding register for one output channel.
module rr_dmux_chan #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    // A load wins over a drain, so a word can be replaced in the cycle it leaves.
    // A drained register is zeroed, so the data output reads 0 whenever it is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            dout <= din;
            vld  <= 1'b1;
        end else if (drain) begin
            dout <= '0;
            vld  <= 1'b0;
        end
    end

endmodule

module rr_dmux_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       dest,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic [7:0]       acc_cnt
);

    localparam int NUM_CH = 4;

    logic [1:0]                   tgt;
    logic                         accept;
    logic [NUM_CH-1:0]            load;
    logic [NUM_CH-1:0][WIDTH-1:0] ch_data;

    // Pick the target channel: the pointer in round-robin mode, dest in fixed mode.
    always_comb begin
        tgt = mode ? dest : rr_ptr;
    end

    // Only the target channel gates the input. out_ready can pass straight through
    // to in_ready, which lets a channel take a new word each cycle.
    assign in_ready = !out_valid[tgt] || out_ready[tgt];
    assign accept   = in_valid && in_ready;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_chan
            assign load[k] = accept && (tgt == 2'(k));

            rr_dmux_chan #(.WIDTH(WIDTH)) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load[k]),
                .drain (out_valid[k] && out_ready[k]),
                .din   (in),
                .dout  (ch_data[k]),
                .vld   (out_valid[k])
            );
        end
    endgenerate

    assign a = ch_data[0];
    assign b = ch_data[1];
    assign c = ch_data[2];
    assign d = ch_data[3];

    // Advance the pointer only on round-robin accepts. Count every accept, wrapping at 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 2'd0;
            acc_cnt <= 8'd0;
        end else if (accept) begin
            if (!mode) rr_ptr <= rr_ptr + 2'd1;
            acc_cnt <= acc_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rr_dmux_4bit.sv
// Directed and random checks of rr_dmux_4bit against a per-channel slot model.
module tb_rr_dmux_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_d;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [1:0] dest;
    logic [3:0] a, b, c, d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;
    logic [7:0] acc_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: one slot per channel, plus the pointer and the accept count.
    int m_data [4];
    bit m_full [4];
    int m_ptr;
    int m_cnt;

    rr_dmux_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .dest      (dest),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_data[k] = 0;
            m_full[k] = 0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endtask

    function automatic int m_tgt();
        return mode ? int'(dest) : m_ptr;
    endfunction

    function automatic bit m_ready();
        return !m_full[m_tgt()] || out_ready[m_tgt()];
    endfunction

    task automatic check_outs(input string tag);
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) ev[k] = m_full[k];
        chk({tag, ".a"}, 32'(a), 32'(m_data[0]));
        chk({tag, ".b"}, 32'(b), 32'(m_data[1]));
        chk({tag, ".c"}, 32'(c), 32'(m_data[2]));
        chk({tag, ".d"}, 32'(d), 32'(m_data[3]));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".rr_ptr"}, 32'(rr_ptr), 32'(m_ptr));
        chk({tag, ".acc_cnt"}, 32'(acc_cnt), 32'(m_cnt));
    endtask

    // Run one clock: drive inputs, check in_ready mid-cycle, then advance the
    // model at the edge and compare all registered outputs.
    task automatic cycle(input string tag, input bit vin, input int din, input bit m,
                         input int dst, input logic [3:0] ordy);
        int  t;
        bit  acc;
        in_valid  = vin;
        in_d      = 4'(din);
        mode      = m;
        dest      = 2'(dst);
        out_ready = ordy;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        t   = m_tgt();
        acc = vin && m_ready();
        for (int k = 0; k < 4; k++) begin
            if (acc && k == t) begin
                m_data[k] = din % 16;
                m_full[k] = 1;
            end else if (m_full[k] && ordy[k]) begin
                m_data[k] = 0;
                m_full[k] = 0;
            end
        end
        if (acc) begin
            if (!m) m_ptr = (m_ptr + 1) % 4;
            m_cnt = (m_cnt + 1) % 256;
        end
        #1;
        check_outs(tag);
    endtask

    // Pull reset between edges, hold it across one edge with a word offered,
    // then release it away from the edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_d     = 4'hF;
        mode     = 1'b0;
        out_ready = 4'h0;
        #1;
        model_clear();
        check_outs({tag, ".async"});
        chk({tag, ".in_ready_rst"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_outs({tag, ".held"});
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_d = 0; in_valid = 0; mode = 0; dest = 0; out_ready = 0;
        model_clear();
        #3;
        check_outs("por");
        chk("por.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin fill with everything draining: a,b,c,d,a.
        for (int i = 1; i <= 5; i++) cycle("rr5", 1, i, 0, 0, 4'hF);
        chk("rr5.a_last", 32'(a), 32'd5);
        chk("rr5.cnt", 32'(acc_cnt), 32'd5);
        chk("rr5.ptr", 32'(rr_ptr), 32'd1);

        // Fill all channels with nobody draining, then stall, then a drains and reloads.
        do_reset("r1");
        for (int i = 1; i <= 4; i++) cycle("fill", 1, i, 0, 0, 4'h0);
        chk("fill.full", 32'(out_valid), 32'hF);
        cycle("stall", 1, 5, 0, 0, 4'h0);
        chk("stall.cnt", 32'(acc_cnt), 32'd4);
        cycle("swap", 1, 5, 0, 0, 4'b0001);
        chk("swap.a", 32'(a), 32'd5);
        chk("swap.vld", 32'(out_valid), 32'hF);

        // Fixed destination c, draining every cycle.
        do_reset("r2");
        cycle("fix", 1, 9, 1, 2, 4'b0100);
        cycle("fix", 1, 10, 1, 2, 4'b0100);
        cycle("fix", 1, 11, 1, 2, 4'b0100);
        chk("fix.c", 32'(c), 32'hB);
        chk("fix.vld", 32'(out_valid), 32'b0100);
        chk("fix.ptr", 32'(rr_ptr), 32'd0);

        // b is full and blocked: no word goes anywhere else.
        do_reset("r3");
        cycle("blk", 1, 7, 1, 1, 4'h0);
        cycle("blk", 1, 8, 1, 1, 4'h0);
        chk("blk.vld", 32'(out_valid), 32'b0010);
        chk("blk.b", 32'(b), 32'd7);

        // Build out_valid=0101 with acc_cnt=7, then reset asynchronously.
        do_reset("r4");
        cycle("pre", 1, 1, 1, 0, 4'h0);
        cycle("pre", 1, 2, 1, 2, 4'h0);
        for (int i = 0; i < 5; i++) cycle("pre", 1, 3 + i, 1, 0, 4'b0001);
        chk("pre.vld", 32'(out_valid), 32'b0101);
        chk("pre.cnt", 32'(acc_cnt), 32'd7);
        do_reset("r5");
        cycle("post", 1, 3, 0, 0, 4'h0);
        chk("post.a", 32'(a), 32'd3);
        chk("post.cnt", 32'(acc_cnt), 32'd1);

        // 256 words at full rate: count wraps back to zero, pointer back to a.
        do_reset("r6");
        for (int i = 0; i < 256; i++) cycle("wrap", 1, i, 0, 0, 4'hF);
        chk("wrap.cnt", 32'(acc_cnt), 32'd0);
        chk("wrap.ptr", 32'(rr_ptr), 32'd0);

        // Random traffic, with one mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("r7");
            cycle("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_dmux_4bit.md
RR_DMUX_4BIT -- requirements
Module: rr_dmux_4bit

Interface
REQ-001 Parameter: WIDTH, 4, data width of input word and each output channel; all requirements below use WIDTH=4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in  input  4  input data word.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input this cycle; transfer when in_valid && in_ready at rising edge.
REQ-007 mode  input  1  0 = round-robin distribution, 1 = fixed destination.
REQ-008 dest  input  2  destination channel when mode=1 (0=a, 1=b, 2=c, 3=d).
REQ-009 a, b, c, d  output  4 each  channel data, driven from per-channel holding registers.
REQ-010 out_valid  output  4  bit k set = channel k register holds an undelivered word (bit0=a ... bit3=d).
REQ-011 out_ready  input  4  bit k set = channel k consumer takes word; delivery when out_valid[k] && out_ready[k] at rising edge.
REQ-012 rr_ptr  output  2  current round-robin target channel.
REQ-013 acc_cnt  output  8  count of accepted input words.

Function
REQ-014 Target channel tgt SHALL be rr_ptr when mode=0 and dest when mode=1, evaluated combinationally each cycle.
REQ-015 in_ready SHALL equal (!out_valid[tgt]) || out_ready[tgt]; combinational path out_ready->in_ready permitted; no other channel affects in_ready.
REQ-016 No skipping: if tgt is full and not draining, in_ready=0 and the word waits; order of distribution never changes.
REQ-017 On accept, holding register tgt SHALL load in and out_valid[tgt] SHALL be 1 next cycle; input-to-output latency exactly 1 cycle.
REQ-018 On delivery of channel k without a simultaneous accept to k, register k SHALL clear to 0 and out_valid[k] to 0.
REQ-019 Simultaneous delivery and accept on same channel: register loads new word, out_valid[k] stays 1 (full throughput, one word/cycle per channel).
REQ-020 Non-targeted channels hold data and valid until delivered; out_valid[k]=1 with out_ready[k]=0 SHALL keep data stable.
REQ-021 On each accept with mode=0, rr_ptr SHALL increment by 1 modulo 4 (3 -> 0); with mode=1, rr_ptr SHALL hold.
REQ-022 Switching mode 1 -> 0 resumes round-robin from the held rr_ptr; mode changes take effect in the same cycle, no flush.
REQ-023 acc_cnt SHALL increment by 1 on every accept in either mode, wrapping 255 -> 0.
REQ-024 in_valid=0 SHALL cause no state change except deliveries.
REQ-025 Data on a..d SHALL be 0 whenever the corresponding out_valid bit is 0.

Reset
REQ-026 rst_n low SHALL immediately (without clock) force a=b=c=d=0, out_valid=0, rr_ptr=0, acc_cnt=0.
REQ-027 Reset mid-transfer SHALL discard all held words; no delivery reported for them.
REQ-028 in_ready SHALL still follow REQ-015 during reset (evaluates to 1, all channels empty); no accepts are recorded while rst_n is low.
REQ-029 First accept after rst_n rises SHALL go to channel a in mode=0.

Verification
REQ-030 After reset, mode=0, out_ready=4'b1111, in_valid=1 with in=1,2,3,4,5 on consecutive cycles -> one cycle later each: a=1, b=2, c=3, d=4, a=5; rr_ptr 0,1,2,3,0,1; acc_cnt=5.
REQ-031 mode=0, out_ready=0, push 4 words -> out_valid=4'b1111, 5th word: in_ready=0, state unchanged; raise out_ready[0] -> 5th accepted into a same cycle as a delivers, out_valid[0] stays 1.
REQ-032 mode=1, dest=2, out_ready[2]=1, push 9,A,B -> c shows 9,A,B on successive cycles, rr_ptr unchanged, other out_valid bits 0.
REQ-033 mode=1 dest=1 with b full and out_ready[1]=0 -> in_ready=0 even though a, c, d empty.
REQ-034 Assert rst_n=0 between clock edges with out_valid=4'b0101 and acc_cnt=7 -> all outputs 0 before next edge; next accept goes to a, acc_cnt=1.
REQ-035 Push 256 words continuously with all out_ready=1 -> acc_cnt returns to 0, rr_ptr=0, no stall cycles.
